// File: rtl/mbinit_pkg.sv
// rtl/mbinit_pkg.sv - Shared MBINIT sideband message codes and CAL FSM state encoding.
package mbinit_pkg;

  localparam logic [3:0] MBINIT_CAL_DONE_REQ  = 4'b0011;
  localparam logic [3:0] MBINIT_CAL_DONE_RESP = 4'b0100;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_REQ  = 3'd1,
    WAIT      = 3'd2,
    SEND_RESP = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } cal_state_e;

endpackage

// File: rtl/ltsm_timeout_cnt.sv
// rtl/ltsm_timeout_cnt.sv - Saturating training timeout counter shared by MBINIT stages.
module ltsm_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd800000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Only meaningful while counting, so a held count in DONE never fires.
  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/mbinit_cal.sv
// rtl/mbinit_cal.sv - MBINIT.CAL handshake: exchange CAL done req/resp with the partner.
module mbinit_cal
  import mbinit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd800000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_MBINIT_CAL_Start_en,
  input  logic [3:0] i_RX_SbMessage,
  input  logic       i_msg_valid,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutDatat_Module,
  output logic       o_MBINIT_CAL_end,
  output logic       o_train_error_req
);

  cal_state_e r_state, w_ns;
  logic       r_req_rcvd, r_resp_rcvd, r_resp_sent;
  logic       w_counting, w_expired;
  logic [3:0] r_tx;
  logic       r_valid, r_end, r_err;

  assign w_counting = (r_state == SEND_REQ) || (r_state == WAIT) || (r_state == SEND_RESP);

  ltsm_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .i_enable  (w_counting),
    .i_clear   ((r_state == IDLE) || !i_MBINIT_CAL_Start_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_ns;
  end

  always_comb begin
    w_ns = r_state;
    if (!i_MBINIT_CAL_Start_en) begin
      w_ns = IDLE;
    end else if (w_expired) begin
      w_ns = ERROR;
    end else begin
      case (r_state)
        IDLE:      if (!i_Busy_SideBand) w_ns = SEND_REQ;
        SEND_REQ:  if (i_falling_edge_busy) w_ns = WAIT;
        WAIT: begin
          if (r_req_rcvd && !r_resp_sent && !i_Busy_SideBand) w_ns = SEND_RESP;
          else if (r_resp_rcvd && r_resp_sent)                w_ns = DONE;
        end
        SEND_RESP: if (i_falling_edge_busy) w_ns = WAIT;
        default:   w_ns = r_state;
      endcase
    end
  end

  // Partner messages are latched in every state, including IDLE, so an early req is not lost.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_req_rcvd  <= 1'b0;
      r_resp_rcvd <= 1'b0;
      r_resp_sent <= 1'b0;
    end else if (!i_MBINIT_CAL_Start_en) begin
      r_req_rcvd  <= 1'b0;
      r_resp_rcvd <= 1'b0;
      r_resp_sent <= 1'b0;
    end else begin
      if (i_msg_valid && (i_RX_SbMessage == MBINIT_CAL_DONE_REQ))  r_req_rcvd  <= 1'b1;
      if (i_msg_valid && (i_RX_SbMessage == MBINIT_CAL_DONE_RESP)) r_resp_rcvd <= 1'b1;
      if ((r_state == SEND_RESP) && i_falling_edge_busy)           r_resp_sent <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_tx    <= 4'b0000;
      r_valid <= 1'b0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= (w_ns == SEND_REQ) || (w_ns == SEND_RESP);
      r_tx    <= (w_ns == SEND_REQ)  ? MBINIT_CAL_DONE_REQ  :
                 (w_ns == SEND_RESP) ? MBINIT_CAL_DONE_RESP : 4'b0000;
      r_end   <= (w_ns == DONE);
      r_err   <= (w_ns == ERROR);
    end
  end

  assign o_TX_SbMessage         = r_tx;
  assign o_ValidOutDatat_Module = r_valid;
  assign o_MBINIT_CAL_end       = r_end;
  assign o_train_error_req      = r_err;

endmodule

// File: tb/tb_mbinit_cal.sv
// tb/tb_mbinit_cal.sv - Directed/randomized bench for mbinit_cal with transaction-level expectations.
module tb_mbinit_cal;

  localparam logic [3:0] C_REQ  = 4'b0011;
  localparam logic [3:0] C_RESP = 4'b0100;
  // Expected {train_error, cal_end, valid, tx[3:0]}
  localparam logic [6:0] O_IDLE = 7'b000_0000;
  localparam logic [6:0] O_REQ  = 7'b001_0011;
  localparam logic [6:0] O_RESP = 7'b001_0100;
  localparam logic [6:0] O_DONE = 7'b010_0000;
  localparam logic [6:0] O_ERR  = 7'b100_0000;
  localparam int         TO     = 100;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy = 1'b0;
  logic       fall = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] rx = 4'b0000;
  logic [3:0] tx;
  logic       tx_valid, cal_end, train_err;
  logic [6:0] w_obs;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign w_obs = {train_err, cal_end, tx_valid, tx};

  mbinit_cal #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK                    (CLK),
    .rst_n                  (rst_n),
    .i_MBINIT_CAL_Start_en  (start),
    .i_RX_SbMessage         (rx),
    .i_msg_valid            (valid),
    .i_Busy_SideBand        (busy),
    .i_falling_edge_busy    (fall),
    .o_TX_SbMessage         (tx),
    .o_ValidOutDatat_Module (tx_valid),
    .o_MBINIT_CAL_end       (cal_end),
    .o_train_error_req      (train_err)
  );

  task automatic chk(input string tag, input logic [6:0] e);
    checks++;
    assert (w_obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, w_obs, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] noise_code();
    logic [3:0] c;
    c = 4'($urandom_range(0, 15));
    if (c == C_REQ || c == C_RESP) c = c ^ 4'b1000;
    return c;
  endfunction

  // Cycles of unrelated traffic (other codes, or CAL codes without valid) must not move the outputs.
  task automatic hold(input int n, input string tag, input logic [6:0] e, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        valid = 1'($urandom_range(0, 1));
        rx    = valid ? noise_code() : C_REQ;
      end
      tick();
      chk(tag, e);
    end
    valid = 1'b0;
    rx    = 4'b0000;
  endtask

  task automatic pulse_fall(input string tag, input logic [6:0] e);
    fall = 1'b1;
    busy = 1'b0;
    tick();
    fall = 1'b0;
    chk(tag, e);
  endtask

  task automatic rx_msg(input logic [3:0] code, input string tag, input logic [6:0] e);
    valid = 1'b1;
    rx    = code;
    tick();
    valid = 1'b0;
    rx    = 4'b0000;
    chk(tag, e);
  endtask

  task automatic start_req(input string tag);
    start = 1'b1;
    busy  = 1'b0;
    tick();
    chk(tag, O_REQ);
    busy  = 1'b1;
  endtask

  initial begin
    int k;
    repeat (2) tick();
    chk("reset_outputs", O_IDLE);
    rst_n = 1'b1;
    hold(3, "idle_after_reset", O_IDLE, 1);

    // Nominal handshake
    start_req("nom_req");
    hold($urandom_range(1, 5), "nom_req_hold", O_REQ, 1);
    pulse_fall("nom_wait", O_IDLE);
    hold($urandom_range(1, 5), "nom_wait_noise", O_IDLE, 1);
    rx_msg(C_REQ, "nom_req_rx", O_IDLE);
    tick(); chk("nom_resp", O_RESP);
    busy = 1'b1;
    hold($urandom_range(1, 5), "nom_resp_hold", O_RESP, 0);
    pulse_fall("nom_resp_sent", O_IDLE);
    rx_msg(C_REQ, "nom_dup_req", O_IDLE);
    hold(3, "nom_dup_ignored", O_IDLE, 0);
    rx_msg(C_RESP, "nom_resp_rx", O_IDLE);
    tick(); chk("nom_done", O_DONE);
    hold($urandom_range(2, 6), "nom_done_hold", O_DONE, 1);
    start = 1'b0;
    tick(); chk("nom_exit", O_IDLE);

    // Partner req latched while still in IDLE
    start = 1'b1; busy = 1'b1;
    tick(); chk("early_idle", O_IDLE);
    rx_msg(C_REQ, "early_req_rx", O_IDLE);
    hold($urandom_range(1, 4), "early_idle_hold", O_IDLE, 0);
    busy = 1'b0;
    tick(); chk("early_req", O_REQ);
    busy = 1'b1;
    hold($urandom_range(1, 4), "early_req_hold", O_REQ, 0);
    pulse_fall("early_wait", O_IDLE);
    tick(); chk("early_resp", O_RESP);
    busy = 1'b1;
    hold($urandom_range(1, 4), "early_resp_hold", O_RESP, 0);
    pulse_fall("early_resp_sent", O_IDLE);
    rx_msg(C_RESP, "early_resp_rx", O_IDLE);
    tick(); chk("early_done", O_DONE);
    start = 1'b0;
    tick(); chk("early_exit", O_IDLE);

    // Partner resp before partner req
    start_req("rf_req");
    pulse_fall("rf_wait", O_IDLE);
    rx_msg(C_RESP, "rf_resp_rx", O_IDLE);
    hold($urandom_range(2, 6), "rf_no_done", O_IDLE, 1);
    rx_msg(C_REQ, "rf_req_rx", O_IDLE);
    tick(); chk("rf_resp", O_RESP);
    busy = 1'b1;
    hold($urandom_range(1, 4), "rf_resp_hold", O_RESP, 0);
    pulse_fall("rf_resp_sent", O_IDLE);
    tick(); chk("rf_done", O_DONE);
    start = 1'b0;
    tick(); chk("rf_exit", O_IDLE);

    // Abort mid-WAIT clears the latched req
    start_req("ab_req");
    pulse_fall("ab_wait", O_IDLE);
    busy = 1'b1;
    rx_msg(C_REQ, "ab_req_rx", O_IDLE);
    hold(2, "ab_busy_block", O_IDLE, 0);
    start = 1'b0; busy = 1'b0;
    tick(); chk("ab_idle", O_IDLE);
    hold(2, "ab_idle_hold", O_IDLE, 0);
    start_req("ab_restart_req");
    pulse_fall("ab_restart_wait", O_IDLE);
    hold(4, "ab_flags_cleared", O_IDLE, 0);
    rx_msg(C_REQ, "ab_fresh_req", O_IDLE);
    tick(); chk("ab_resp", O_RESP);
    pulse_fall("ab_resp_sent", O_IDLE);
    rx_msg(C_RESP, "ab_resp_rx", O_IDLE);
    tick(); chk("ab_done", O_DONE);
    start = 1'b0;
    tick(); chk("ab_exit", O_IDLE);

    // Timeout: error exactly TO cycles after entering SEND_REQ, regardless of where it stalls
    k = $urandom_range(5, 50);
    start_req("to_req");
    for (int i = 1; i <= TO; i++) begin
      fall = (i == k);
      if (i == k) busy = 1'b0;
      tick();
      fall = 1'b0;
      chk((i == TO) ? "to_error" : "to_pre_error",
          (i == TO) ? O_ERR : ((i < k) ? O_REQ : O_IDLE));
    end
    hold($urandom_range(3, 8), "to_err_hold", O_ERR, 1);
    start = 1'b0;
    tick(); chk("to_exit", O_IDLE);

    // Reset asserted during SEND_RESP
    start = 1'b1; busy = 1'b1;
    rx_msg(C_REQ, "rst_req_rx", O_IDLE);
    busy = 1'b0;
    tick(); chk("rst_req", O_REQ);
    pulse_fall("rst_wait", O_IDLE);
    tick(); chk("rst_resp", O_RESP);
    busy = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk("rst_async_clear", O_IDLE);
    start = 1'b0; busy = 1'b0;
    tick();
    rst_n = 1'b1;
    hold(4, "rst_release_idle", O_IDLE, 0);
    start = 1'b1;
    tick(); chk("rst_restart_req", O_REQ);
    start = 1'b0;
    tick(); chk("rst_exit", O_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
